// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchroniser, start-bit qualification, mid-bit sampling.
// Define UART_RX_PARITY_EN to receive 8E1 frames and flag even-parity errors on o_parity_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_serial,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_act,
  output logic       o_frame_err,
  output logic       o_parity_err
);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] MID_CNT  = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;

  state_t      state_reg;
  logic        rx_meta_reg;
  logic        rx_s_reg;
  logic [15:0] clk_cnt_reg;
  logic [2:0]  bit_idx_reg;
  logic [7:0]  shreg_reg;
`ifdef UART_RX_PARITY_EN
  logic        parity_bit_reg;
  logic        parity_err_reg;
  assign o_parity_err = parity_err_reg;
`else
  assign o_parity_err = 1'b0;
`endif

  // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= i_rx_serial;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      clk_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      shreg_reg      <= '0;
      o_rx_dv        <= 1'b0;
      o_rx_byte      <= '0;
      o_rx_act       <= 1'b0;
      o_frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      o_rx_dv     <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          clk_cnt_reg <= '0;
          bit_idx_reg <= '0;
          o_rx_act    <= 1'b0;
          if (!rx_s_reg) begin
            o_rx_act  <= 1'b1;
            state_reg <= START;
          end
        end
        START: begin
          o_rx_act <= 1'b1;
          if (clk_cnt_reg == MID_CNT) begin
            clk_cnt_reg <= '0;
            if (!rx_s_reg) begin
              state_reg <= DATA;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              o_rx_act  <= 1'b0;
              state_reg <= IDLE;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 16'd1;
          end
        end
        DATA: begin
          if (clk_cnt_reg == LAST_CNT) begin
            clk_cnt_reg            <= '0;
            shreg_reg[bit_idx_reg] <= rx_s_reg;
            if (bit_idx_reg == 3'd7) begin
              bit_idx_reg <= '0;
`ifdef UART_RX_PARITY_EN
              state_reg   <= PARITY;
`else
              state_reg   <= STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt_reg == LAST_CNT) begin
            clk_cnt_reg    <= '0;
            parity_bit_reg <= rx_s_reg;
            state_reg      <= STOP;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 16'd1;
          end
        end
`endif
        STOP: begin
          if (clk_cnt_reg == LAST_CNT) begin
            clk_cnt_reg <= '0;
            state_reg   <= CLEANUP;
            if (rx_s_reg) begin
              o_rx_byte <= shreg_reg;
              o_rx_dv   <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_reg <= ^{shreg_reg, parity_bit_reg};
`endif
            end else begin
              o_frame_err <= 1'b1;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 16'd1;
          end
        end
        CLEANUP: begin
          // Hold here through a break so a stuck-low line cannot start a bogus frame.
          if (rx_s_reg) begin
            o_rx_act  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          o_rx_act  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx (CLKS_PER_BIT=4); expected events come from a
// frame-level model of what each transmitted frame should yield.
module tb_uart_rx;
  localparam int CPB = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FRAME_BITS = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FRAME_BITS = 10;
`endif
  localparam int LAT_NOM = 2 + (CPB - 1) / 2 + (FRAME_BITS - 1) * CPB + 1;
  localparam logic [31:0] FE_EV = 32'h1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       o_rx_dv;
  logic [7:0] o_rx_byte;
  logic       o_rx_act;
  logic       o_frame_err;
  logic       o_parity_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx_serial(rx),
    .o_rx_dv(o_rx_dv),
    .o_rx_byte(o_rx_byte),
    .o_rx_act(o_rx_act),
    .o_frame_err(o_frame_err),
    .o_parity_err(o_parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Observed output events: good byte = {parity_err, byte}, framing error = FE_EV.
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  int dv_cyc_q[$];
  logic [31:0] act_after_q[$];
  int act_cycles;
  bit dv_d = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_rx_dv || o_frame_err) check("dv_fe_exclusive", 32'(o_rx_dv & o_frame_err), 32'd0);
      if (o_parity_err) check("perr_needs_dv", 32'(o_rx_dv), 32'd1);
      if (o_rx_dv) begin
        obs_q.push_back(32'({o_parity_err, o_rx_byte}));
        dv_cyc_q.push_back(cyc);
      end
      if (o_frame_err) obs_q.push_back(FE_EV);
      if (dv_d) act_after_q.push_back(32'(o_rx_act));
      if (o_rx_act) act_cycles++;
      dv_d = o_rx_dv;
    end else begin
      dv_d = 1'b0;
    end
  end

  function automatic logic [31:0] model(input logic [7:0] b, input logic stop_bit, input logic pbit);
    if (!stop_bit) return FE_EV;
    return 32'({PAR_EN && (^{b, pbit}), b});
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  int start_cyc;
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pbit);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (PAR_EN) send_bit(pbit);
    send_bit(stop_bit);
  endtask

  task automatic clear_mon();
    obs_q.delete();
    exp_q.delete();
    dv_cyc_q.delete();
    act_after_q.delete();
    act_cycles = 0;
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_nevents"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  logic [7:0] last_good;
  int lat;

  initial begin
    rx = 1'b1;
    rst = 1'b1;
    tick(3);
    check("rst_dv", 32'(o_rx_dv), 32'd0);
    check("rst_byte", 32'(o_rx_byte), 32'd0);
    check("rst_act", 32'(o_rx_act), 32'd0);
    check("rst_fe", 32'(o_frame_err), 32'd0);
    check("rst_perr", 32'(o_parity_err), 32'd0);
    rst = 1'b0;
    tick(5);

    // Single frame with latency and o_rx_act release
    clear_mon();
    send_frame(8'hA5, 1'b1, ^8'hA5);
    exp_q.push_back(model(8'hA5, 1'b1, ^8'hA5));
    tick(2 * CPB);
    compare_events("a5");
    check("a5_byte", 32'(o_rx_byte), 32'hA5);
    check("a5_act_after", 32'(act_after_q.size() == 1 && act_after_q[0] == 32'd0), 32'd1);
    if (dv_cyc_q.size() > 0) begin
      lat = dv_cyc_q[0] - start_cyc;
      check("a5_latency", 32'(lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 32'd1);
    end

    // One-clock glitch must be rejected
    clear_mon();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(3 * CPB);
    compare_events("glitch");
    check("glitch_act_len", 32'(act_cycles >= 1 && act_cycles <= 3), 32'd1);
    check("glitch_act_end", 32'(o_rx_act), 32'd0);
    check("glitch_byte", 32'(o_rx_byte), 32'hA5);

    // Good frame, then bad stop bit followed by a break
    clear_mon();
    send_frame(8'h11, 1'b1, ^8'h11);
    exp_q.push_back(model(8'h11, 1'b1, ^8'h11));
    send_frame(8'h3C, 1'b0, ^8'h3C);
    exp_q.push_back(model(8'h3C, 1'b0, ^8'h3C));
    rx = 1'b0;
    tick(20);
    check("break_act_held", 32'(o_rx_act), 32'd1);
    rx = 1'b1;
    tick(3 * FRAME_BITS * CPB);
    compare_events("break");
    check("break_byte", 32'(o_rx_byte), 32'h11);
    check("break_act_end", 32'(o_rx_act), 32'd0);

    // Back-to-back frames without idle gap
    clear_mon();
    send_frame(8'h00, 1'b1, 1'b0);
    exp_q.push_back(model(8'h00, 1'b1, 1'b0));
    send_frame(8'hFF, 1'b1, 1'b0);
    exp_q.push_back(model(8'hFF, 1'b1, 1'b0));
    tick(2 * CPB);
    compare_events("b2b");
    if (dv_cyc_q.size() == 2)
      check("b2b_spacing", 32'(dv_cyc_q[1] - dv_cyc_q[0]), 32'(FRAME_BITS * CPB));

    // Reset in the middle of data bit 3
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(i[0] ? 1'b1 : 1'b0);  // 0x5A bits 0..2 = 0,1,0
    rx = 1'b1;                                                 // 0x5A bit 3
    tick(2);
    check("pre_rst_act", 32'(o_rx_act), 32'd1);
    rst = 1'b1;
    tick(1);
    check("midrst_dv", 32'(o_rx_dv), 32'd0);
    check("midrst_byte", 32'(o_rx_byte), 32'd0);
    check("midrst_act", 32'(o_rx_act), 32'd0);
    check("midrst_fe", 32'(o_frame_err), 32'd0);
    check("midrst_perr", 32'(o_parity_err), 32'd0);
    rst = 1'b0;
    rx = 1'b1;
    tick(3 * CPB);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    exp_q.push_back(model(8'hC3, 1'b1, ^8'hC3));
    tick(2 * CPB);
    compare_events("after_rst");
    check("after_rst_byte", 32'(o_rx_byte), 32'hC3);

    // Parity pass/fail on 0x07 (odd weight, so even parity bit is 1)
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0);
    exp_q.push_back(model(8'h07, 1'b1, 1'b0));
    send_frame(8'h07, 1'b1, 1'b1);
    exp_q.push_back(model(8'h07, 1'b1, 1'b1));
    tick(2 * CPB);
    compare_events("par07");

    // Randomised frames, some with bad stop bits and random parity bits
    clear_mon();
    last_good = 8'h07;
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      logic good;
      logic pbit;
      b = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      pbit = 1'($urandom_range(0, 1));
      send_frame(b, good, pbit);
      exp_q.push_back(model(b, good, pbit));
      if (good) last_good = b;
      rx = 1'b1;
      tick(good ? int'($urandom_range(0, 6)) : int'($urandom_range(CPB, 3 * CPB)));
    end
    tick(2 * CPB);
    compare_events("rand");
    check("rand_byte_held", 32'(o_rx_byte), 32'(last_good));
    check("rand_act_idle", 32'(o_rx_act), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; downstream partner of the UART transmitter.
- Consumes the serial line and returns received bytes to the fabric.
- Synchronises the asynchronous line, finds the start bit, samples each bit at mid-bit and checks the stop bit.
- Presents each byte with a one-cycle valid pulse, or a one-cycle framing-error pulse.

Parameters:
- CLKS_PER_BIT, 87: i_clk cycles per UART bit, i.e. clock frequency / baud. Legal range 2..65535. Must match the transmitter's value.

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_rx_serial  in  1  asynchronous serial line; idle high
- o_rx_dv  out  1  one-cycle pulse; o_rx_byte is valid
- o_rx_byte  out  8  last correctly framed byte; held between pulses
- o_rx_act  out  1  high while a frame is being received
- o_frame_err  out  1  one-cycle pulse; stop bit sampled low
- o_parity_err  out  1  one-cycle parity-error pulse; tied 0 without the macro

Behaviour:
- Reset (i_rst high at a rising edge):
  - state = IDLE; counters = 0.
  - Both synchroniser flops = 1.
  - o_rx_dv, o_frame_err, o_parity_err, o_rx_act = 0; o_rx_byte = 0x00.
  - Reset overrides any state, including mid-frame. The partial frame is discarded and no pulse is produced.
- Synchroniser:
  - 2-flop chain on i_rx_serial produces rx_s.
  - All decisions use rx_s. Fixed input latency is 2 cycles.
- Counters:
  - clk_cnt: 16 bits, counts 0..CLKS_PER_BIT-1.
  - bit_idx: 3 bits.
  - Shift register: 8 bits, LSB received first.
- IDLE:
  - clk_cnt = 0, bit_idx = 0, o_rx_act = 0.
  - rx_s == 0 -> START.
- START:
  - o_rx_act = 1; clk_cnt increments.
  - At clk_cnt == (CLKS_PER_BIT-1)/2 (integer division), mid start bit:
    - rx_s == 0: clk_cnt = 0, go to DATA.
    - rx_s == 1: glitch; go to IDLE with no flags raised.
- DATA:
  - At clk_cnt == CLKS_PER_BIT-1: store rx_s into shreg[bit_idx]; clk_cnt = 0.
  - bit_idx 0..6: increment bit_idx and stay in DATA.
  - bit_idx 7: bit_idx = 0; go to STOP (or PARITY when the macro is defined).
  - Every sample lands at mid-bit.
- STOP:
  - At clk_cnt == CLKS_PER_BIT-1, sample rx_s.
  - rx_s == 1: o_rx_byte <= shreg and o_rx_dv = 1 for exactly one cycle on that same edge; go to CLEANUP.
  - rx_s == 0: o_frame_err = 1 for one cycle; o_rx_byte unchanged; o_rx_dv stays 0; go to CLEANUP.
- CLEANUP:
  - Stay while rx_s == 0 (break or stuck-low line); go to IDLE on the first cycle with rx_s == 1.
  - o_rx_act drops to 0 when IDLE is entered.
  - After a good stop bit the line is already high, so CLEANUP lasts 1 cycle.
  - This supports back-to-back frames: the next start edge arrives half a bit or more later.
- Latency: the o_rx_dv edge comes 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles after the falling edge on i_rx_serial (±1 cycle for sync phase).
- Pulses never overlap except o_rx_dv with o_parity_err.
- o_rx_dv and o_frame_err are mutually exclusive.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1 (even parity).
  - A PARITY state follows DATA and samples one bit at mid-bit.
  - At a good stop bit, o_parity_err pulses together with o_rx_dv if ^{shreg, parity_bit} != 0.
  - The byte is still delivered when parity fails.
  - On a framing error o_parity_err stays 0.
- Undefined:
  - No PARITY state; frame is 8N1.
  - o_parity_err is driven constant 0.

Test Plan (bench uses CLKS_PER_BIT=4; tx block used as stimulus where convenient):
1. Frame 0xA5, 8N1, line idle high before and after -> single o_rx_dv pulse with o_rx_byte=0xA5; o_frame_err=0; o_rx_act low 1 cycle after the pulse.
2. i_rx_serial low for 1 clk then high -> no o_rx_dv, no o_frame_err; o_rx_act high ≤3 cycles then 0; o_rx_byte unchanged.
3. Receive 0x11, then 0x3C with stop bit 0, then line held low 20 clks before going high -> o_frame_err one pulse, no o_rx_dv, o_rx_byte stays 0x11, o_rx_act high until rx_s returns high; no spurious frame.
4. 0x00 then 0xFF back-to-back, no idle gap -> two o_rx_dv pulses 40 cycles apart, bytes 0x00 then 0xFF.
5. i_rst asserted during data bit 3 of 0x5A -> all outputs 0 on the next edge; next full 0xC3 frame is received correctly.
6. With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> o_rx_dv, o_rx_byte=0x07, o_parity_err=1 same cycle. 0x07 with parity bit 1 -> o_parity_err=0.
